// File: rtl/axi_master_connector_spill_pkg.sv
// AXI4 channel and request/response struct definitions shared by the master connector
// and everything that talks to it through the struct interface.
package axi_conf;

    localparam int unsigned AXI_ADDR_WIDTH   = 32;
    localparam int unsigned AXI_DATA_WIDTH   = 32;
    localparam int unsigned AXI_STRB_WIDTH   = AXI_DATA_WIDTH / 8;
    localparam int unsigned AXI_ID_WIDTH     = 8;
    localparam int unsigned AXI_AWUSER_WIDTH = 1;
    localparam int unsigned AXI_WUSER_WIDTH  = 1;
    localparam int unsigned AXI_BUSER_WIDTH  = 1;
    localparam int unsigned AXI_ARUSER_WIDTH = 1;
    localparam int unsigned AXI_RUSER_WIDTH  = 1;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]     id;
        logic [AXI_ADDR_WIDTH-1:0]   addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic                        lock;
        logic [3:0]                  cache;
        logic [2:0]                  prot;
        logic [3:0]                  qos;
        logic [3:0]                  region;
        logic [5:0]                  atop;
        logic [AXI_AWUSER_WIDTH-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0]  data;
        logic [AXI_STRB_WIDTH-1:0]  strb;
        logic                       last;
        logic [AXI_WUSER_WIDTH-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]    id;
        logic [1:0]                 resp;
        logic [AXI_BUSER_WIDTH-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]     id;
        logic [AXI_ADDR_WIDTH-1:0]   addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic                        lock;
        logic [3:0]                  cache;
        logic [2:0]                  prot;
        logic [3:0]                  qos;
        logic [3:0]                  region;
        logic [AXI_ARUSER_WIDTH-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]    id;
        logic [AXI_DATA_WIDTH-1:0]  data;
        logic [1:0]                 resp;
        logic                       last;
        logic [AXI_RUSER_WIDTH-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;

endpackage

// File: rtl/axi_master_connector_spill_skid_buf.sv
// Generic 2-entry register slice: ready, valid and payload leave straight from flops,
// and a full beat per cycle flows through with one cycle of latency.
module axi_skid_buf #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e occ_q, occ_d;
    T     head_q, head_d;
    T     tail_q, tail_d;
    logic push, pop;

    assign ready_o = run_i & (occ_q != OCC_FULL);
    assign valid_o = (occ_q != OCC_EMPTY);
    assign data_o  = head_q;
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    // NOTE: every signal written here gets its hold value first, so no path leaves one unassigned (no latch).
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = data_i;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    head_d = data_i;
                end else if (push) begin
                    tail_d = data_i;
                    occ_d  = OCC_FULL;
                end else if (pop) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // NOTE: payload flops are reset too, so the master ports show zeros rather than X out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            // NOTE: non-blocking here so all flops update from the same pre-edge values.
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/axi_master_connector_spill.sv
// Flattens the struct AXI interface onto m_axi_* ports with a registered 2-entry
// slice on every channel; ready outputs stay low until the cycle after reset release.
module axi_master_connector_spill
    import axi_conf::*;
#(
    parameter int unsigned DATA_WIDTH   = AXI_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = AXI_ADDR_WIDTH,
    parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH     = AXI_ID_WIDTH,
    parameter int unsigned AWUSER_WIDTH = AXI_AWUSER_WIDTH,
    parameter int unsigned WUSER_WIDTH  = AXI_WUSER_WIDTH,
    parameter int unsigned BUSER_WIDTH  = AXI_BUSER_WIDTH,
    parameter int unsigned ARUSER_WIDTH = AXI_ARUSER_WIDTH,
    parameter int unsigned RUSER_WIDTH  = AXI_RUSER_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  req_t                    axi_req_i,
    output resp_t                   axi_resp_o,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic [3:0]              m_axi_awregion,
    output logic [AWUSER_WIDTH-1:0] m_axi_awuser,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic [WUSER_WIDTH-1:0]  m_axi_wuser,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic [BUSER_WIDTH-1:0]  m_axi_buser,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic [3:0]              m_axi_arregion,
    output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    logic     run_q;
    aw_chan_t aw_q;
    w_chan_t  w_q;
    ar_chan_t ar_q;
    b_chan_t  b_in, b_q;
    r_chan_t  r_in, r_q;
    logic     aw_ready, w_ready, ar_ready, b_valid, r_valid;
    logic     unused_atop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) run_q <= 1'b0;
        else         run_q <= 1'b1;
    end

    axi_skid_buf #(.T(aw_chan_t)) u_aw_buf (
        .clk_i, .rst_ni, .run_i(run_q),
        .valid_i(axi_req_i.aw_valid), .ready_o(aw_ready), .data_i(axi_req_i.aw),
        .valid_o(m_axi_awvalid), .ready_i(m_axi_awready), .data_o(aw_q)
    );

    axi_skid_buf #(.T(w_chan_t)) u_w_buf (
        .clk_i, .rst_ni, .run_i(run_q),
        .valid_i(axi_req_i.w_valid), .ready_o(w_ready), .data_i(axi_req_i.w),
        .valid_o(m_axi_wvalid), .ready_i(m_axi_wready), .data_o(w_q)
    );

    axi_skid_buf #(.T(ar_chan_t)) u_ar_buf (
        .clk_i, .rst_ni, .run_i(run_q),
        .valid_i(axi_req_i.ar_valid), .ready_o(ar_ready), .data_i(axi_req_i.ar),
        .valid_o(m_axi_arvalid), .ready_i(m_axi_arready), .data_o(ar_q)
    );

    axi_skid_buf #(.T(b_chan_t)) u_b_buf (
        .clk_i, .rst_ni, .run_i(run_q),
        .valid_i(m_axi_bvalid), .ready_o(m_axi_bready), .data_i(b_in),
        .valid_o(b_valid), .ready_i(axi_req_i.b_ready), .data_o(b_q)
    );

    axi_skid_buf #(.T(r_chan_t)) u_r_buf (
        .clk_i, .rst_ni, .run_i(run_q),
        .valid_i(m_axi_rvalid), .ready_o(m_axi_rready), .data_i(r_in),
        .valid_o(r_valid), .ready_i(axi_req_i.r_ready), .data_o(r_q)
    );

    always_comb begin
        b_in      = '0;
        b_in.id   = m_axi_bid;
        b_in.resp = m_axi_bresp;
        b_in.user = m_axi_buser;
        r_in      = '0;
        r_in.id   = m_axi_rid;
        r_in.data = m_axi_rdata;
        r_in.resp = m_axi_rresp;
        r_in.last = m_axi_rlast;
        r_in.user = m_axi_ruser;
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.b_valid  = b_valid;
        axi_resp_o.b        = b_q;
        axi_resp_o.r_valid  = r_valid;
        axi_resp_o.r        = r_q;
    end

    // Atomics have no home on the flat port list; the field rides the buffer and is dropped.
    assign unused_atop = ^aw_q.atop;

    assign m_axi_awid     = aw_q.id;
    assign m_axi_awaddr   = aw_q.addr;
    assign m_axi_awlen    = aw_q.len;
    assign m_axi_awsize   = aw_q.size;
    assign m_axi_awburst  = aw_q.burst;
    assign m_axi_awlock   = aw_q.lock;
    assign m_axi_awcache  = aw_q.cache;
    assign m_axi_awprot   = aw_q.prot;
    assign m_axi_awqos    = aw_q.qos;
    assign m_axi_awregion = aw_q.region;
    assign m_axi_awuser   = aw_q.user;

    assign m_axi_wdata    = w_q.data;
    assign m_axi_wstrb    = w_q.strb;
    assign m_axi_wlast    = w_q.last;
    assign m_axi_wuser    = w_q.user;

    assign m_axi_arid     = ar_q.id;
    assign m_axi_araddr   = ar_q.addr;
    assign m_axi_arlen    = ar_q.len;
    assign m_axi_arsize   = ar_q.size;
    assign m_axi_arburst  = ar_q.burst;
    assign m_axi_arlock   = ar_q.lock;
    assign m_axi_arcache  = ar_q.cache;
    assign m_axi_arprot   = ar_q.prot;
    assign m_axi_arqos    = ar_q.qos;
    assign m_axi_arregion = ar_q.region;
    assign m_axi_aruser   = ar_q.user;

endmodule

// File: tb/tb_axi_master_connector_spill.sv
// Scoreboard bench for axi_master_connector_spill: every accepted beat is queued on entry
// and compared when it leaves the other side, plus explicit timing and reset checks.
module tb_axi_master_connector_spill;
    import axi_conf::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    req_t        axi_req;
    resp_t       axi_resp;
    logic [7:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awlock, m_axi_arlock;
    logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
    logic [3:0]  m_axi_awregion, m_axi_arregion, m_axi_wstrb;
    logic        m_axi_awuser, m_axi_aruser, m_axi_wuser, m_axi_buser, m_axi_ruser;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;

    axi_master_connector_spill dut (
        .clk_i(clk), .rst_ni(rst_n), .axi_req_i(axi_req), .axi_resp_o(axi_resp),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_compared   = 0;
    int n_mismatched = 0;

    aw_chan_t q_aw[$];
    w_chan_t  q_w[$];
    ar_chan_t q_ar[$];
    b_chan_t  q_b[$];
    r_chan_t  q_r[$];
    int       w_out_cyc[$];
    int       ar_out_cyc[$];
    int       ar_acc_cyc = 0;
    int       b_out_n = 0;
    int       r_out_n = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic rdy(input int ch);
        case (ch)
            0:       return axi_resp.aw_ready;
            1:       return axi_resp.w_ready;
            2:       return axi_resp.ar_ready;
            3:       return m_axi_bready;
            default: return m_axi_rready;
        endcase
    endfunction

    // Call at posedge+1 with valid already driven; returns at posedge+1 after the handshake edge.
    task automatic wait_accept(input string tag, input int ch);
        int n = 0;
        @(negedge clk);
        while (!rdy(ch) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 128'(rdy(ch)), 128'd1);
        @(posedge clk);
        #1;
    endtask

    // Output side pops first so a zero-latency path would find an empty queue.
    always @(negedge clk) begin
        aw_chan_t aw_o, aw_i;
        w_chan_t  w_o;
        ar_chan_t ar_o;
        b_chan_t  b_m;
        r_chan_t  r_m;
        if (rst_n) begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_o = '0;
                aw_o.id = m_axi_awid;     aw_o.addr = m_axi_awaddr;   aw_o.len = m_axi_awlen;
                aw_o.size = m_axi_awsize; aw_o.burst = m_axi_awburst; aw_o.lock = m_axi_awlock;
                aw_o.cache = m_axi_awcache; aw_o.prot = m_axi_awprot; aw_o.qos = m_axi_awqos;
                aw_o.region = m_axi_awregion; aw_o.user = m_axi_awuser;
                if (q_aw.size() == 0) check("aw_unexpected", 128'(q_aw.size()), 128'd1);
                else                  check("aw_beat", 128'(aw_o), 128'(q_aw.pop_front()));
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_o.data = m_axi_wdata; w_o.strb = m_axi_wstrb;
                w_o.last = m_axi_wlast; w_o.user = m_axi_wuser;
                w_out_cyc.push_back(cyc);
                if (q_w.size() == 0) check("w_unexpected", 128'(q_w.size()), 128'd1);
                else                 check("w_beat", 128'(w_o), 128'(q_w.pop_front()));
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_o.id = m_axi_arid;     ar_o.addr = m_axi_araddr;   ar_o.len = m_axi_arlen;
                ar_o.size = m_axi_arsize; ar_o.burst = m_axi_arburst; ar_o.lock = m_axi_arlock;
                ar_o.cache = m_axi_arcache; ar_o.prot = m_axi_arprot; ar_o.qos = m_axi_arqos;
                ar_o.region = m_axi_arregion; ar_o.user = m_axi_aruser;
                ar_out_cyc.push_back(cyc);
                if (q_ar.size() == 0) check("ar_unexpected", 128'(q_ar.size()), 128'd1);
                else                  check("ar_beat", 128'(ar_o), 128'(q_ar.pop_front()));
            end
            if (axi_resp.b_valid && axi_req.b_ready) begin
                b_out_n++;
                if (q_b.size() == 0) check("b_unexpected", 128'(q_b.size()), 128'd1);
                else                 check("b_beat", 128'(axi_resp.b), 128'(q_b.pop_front()));
            end
            if (axi_resp.r_valid && axi_req.r_ready) begin
                r_out_n++;
                if (q_r.size() == 0) check("r_unexpected", 128'(q_r.size()), 128'd1);
                else                 check("r_beat", 128'(axi_resp.r), 128'(q_r.pop_front()));
            end

            if (axi_req.aw_valid && axi_resp.aw_ready) begin
                aw_i = axi_req.aw;
                aw_i.atop = '0;
                q_aw.push_back(aw_i);
            end
            if (axi_req.w_valid && axi_resp.w_ready) q_w.push_back(axi_req.w);
            if (axi_req.ar_valid && axi_resp.ar_ready) begin
                q_ar.push_back(axi_req.ar);
                ar_acc_cyc = cyc;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_m.id = m_axi_bid; b_m.resp = m_axi_bresp; b_m.user = m_axi_buser;
                q_b.push_back(b_m);
            end
            if (m_axi_rvalid && m_axi_rready) begin
                r_m.id = m_axi_rid; r_m.data = m_axi_rdata; r_m.resp = m_axi_rresp;
                r_m.last = m_axi_rlast; r_m.user = m_axi_ruser;
                q_r.push_back(r_m);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_all_idle(input string tag);
        check({tag, "_readys"}, 128'({axi_resp.aw_ready, axi_resp.w_ready, axi_resp.ar_ready,
                                      m_axi_bready, m_axi_rready}), 128'd0);
        check({tag, "_valids"}, 128'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                      axi_resp.b_valid, axi_resp.r_valid}), 128'd0);
    endtask

    initial begin
        axi_req       = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid  = 1'b0; m_axi_bid = '0; m_axi_bresp = '0; m_axi_buser = '0;
        m_axi_rvalid  = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
        m_axi_rlast   = 1'b0; m_axi_ruser = '0;

        // Reset and ready release, with an upstream AW already pending.
        axi_req.aw_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_idle("rst");
        rst_n = 1'b1;
        #1 check("aw_ready_before_edge", 128'(axi_resp.aw_ready), 128'd0);
        @(posedge clk);
        #1 check("aw_ready_one_edge", 128'(axi_resp.aw_ready), 128'd1);
        @(posedge clk);
        #1 check("aw_buffered", 128'(m_axi_awvalid), 128'd1);
        #2 rst_n = 1'b0;
        #1 check_all_idle("rst_mid");
        q_aw.delete();
        axi_req.aw_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single AW: visible on the master side one cycle after acceptance.
        m_axi_awready     = 1'b1;
        axi_req.aw        = '0;
        axi_req.aw.id     = 8'h03;
        axi_req.aw.addr   = 32'h1000_0040;
        axi_req.aw.size   = 3'd2;
        axi_req.aw.burst  = 2'b01;
        axi_req.aw.cache  = 4'h3;
        axi_req.aw.prot   = 3'h2;
        axi_req.aw.qos    = 4'h1;
        axi_req.aw.region = 4'h2;
        axi_req.aw.atop   = 6'h2A;
        axi_req.aw.user   = 1'b1;
        axi_req.aw_valid  = 1'b1;
        @(negedge clk);
        check("aw_lat0_valid", 128'(m_axi_awvalid), 128'd0);
        @(posedge clk);
        #1 axi_req.aw_valid = 1'b0;
        @(negedge clk);
        check("aw_lat1_valid", 128'(m_axi_awvalid), 128'd1);
        check("aw_lat1_addr", 128'(m_axi_awaddr), 128'h1000_0040);
        check("aw_lat1_id", 128'(m_axi_awid), 128'h3);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("aw_drained", 128'(m_axi_awvalid), 128'd0);
        @(posedge clk);
        #1;

        // 16-beat W burst into an always-ready sink.
        m_axi_wready = 1'b1;
        w_out_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            axi_req.w.data  = 32'hC0DE_0000 + 32'(i);
            axi_req.w.strb  = 4'hF;
            axi_req.w.last  = (i == 15);
            axi_req.w.user  = 1'(i & 1);
            axi_req.w_valid = 1'b1;
            wait_accept("w", 1);
        end
        axi_req.w_valid = 1'b0;
        for (int k = 0; k < 50 && w_out_cyc.size() < 16; k++) @(negedge clk);
        check("w_beat_count", 128'(w_out_cyc.size()), 128'd16);
        if (w_out_cyc.size() == 16)
            check("w_no_bubble", 128'(w_out_cyc[15] - w_out_cyc[0]), 128'd15);
        @(posedge clk);
        #1;

        // AR backpressure: two beats fill the slice, the third waits for the first pop.
        m_axi_arready = 1'b0;
        ar_out_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            axi_req.ar       = '0;
            axi_req.ar.id    = 8'h10 + 8'(i);
            axi_req.ar.addr  = 32'h2000_0000 + 32'(16 * i);
            axi_req.ar.len   = 8'(i);
            axi_req.ar.size  = 3'd2;
            axi_req.ar.burst = 2'b01;
            axi_req.ar_valid = 1'b1;
            if (i < 2) wait_accept("ar", 2);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ar_full_ready", 128'(axi_resp.ar_ready), 128'd0);
            check("ar_hold_valid", 128'(m_axi_arvalid), 128'd1);
            check("ar_hold_addr", 128'(m_axi_araddr), 128'h2000_0000);
        end
        @(posedge clk);
        #1 m_axi_arready = 1'b1;
        wait_accept("ar", 2);
        axi_req.ar_valid = 1'b0;
        for (int k = 0; k < 50 && ar_out_cyc.size() < 3; k++) @(negedge clk);
        check("ar_beat_count", 128'(ar_out_cyc.size()), 128'd3);
        if (ar_out_cyc.size() > 0)
            check("ar_third_after_pop", 128'(ar_acc_cyc - ar_out_cyc[0]), 128'd1);
        @(posedge clk);
        #1;

        // R burst with upstream r_ready toggling every cycle.
        r_out_n = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rid    = 8'h05;
                    m_axi_rdata  = 32'hA5A5_0000 + 32'(i);
                    m_axi_rresp  = 2'b00;
                    m_axi_rlast  = (i == 3);
                    m_axi_ruser  = 1'b0;
                    wait_accept("r", 4);
                end
                m_axi_rvalid = 1'b0;
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    axi_req.r_ready = (k % 2 == 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        axi_req.r_ready = 1'b0;
        check("r_beat_count", 128'(r_out_n), 128'd4);

        // B response with SLVERR.
        b_out_n          = 0;
        axi_req.b_ready  = 1'b1;
        m_axi_bvalid     = 1'b1;
        m_axi_bid        = 8'h07;
        m_axi_bresp      = 2'b10;
        m_axi_buser      = 1'b1;
        @(negedge clk);
        check("b_lat0_valid", 128'(axi_resp.b_valid), 128'd0);
        check("b_bready", 128'(m_axi_bready), 128'd1);
        @(posedge clk);
        #1 m_axi_bvalid = 1'b0;
        @(negedge clk);
        check("b_lat1_valid", 128'(axi_resp.b_valid), 128'd1);
        check("b_lat1_id", 128'(axi_resp.b.id), 128'h7);
        check("b_lat1_resp", 128'(axi_resp.b.resp), 128'h2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b_drained", 128'(axi_resp.b_valid), 128'd0);
        check("b_beat_count", 128'(b_out_n), 128'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty",
              128'(q_aw.size() + q_w.size() + q_ar.size() + q_b.size() + q_r.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/axi_master_connector_spill.md
Name: axi_master_connector_spill

Overview:
- Converts an axi_conf::req_t/resp_t pair (pulp-platform struct interface) into flat AXI4 master ports m_axi_*.
- Inserts a 2-entry skid buffer on each of the five channels (AW, W, B, AR, R), so every valid, ready and payload path crossing the boundary is registered.
- Sits between internal IO-PMP/crossbar logic and external Verilog-style AXI slaves; full throughput, 1-cycle latency per channel.

Parameters:
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, address width in bits
- STRB_WIDTH, DATA_WIDTH/8, strobe width
- ID_WIDTH, 8, AXI ID width
- AWUSER_WIDTH / WUSER_WIDTH / BUSER_WIDTH / ARUSER_WIDTH / RUSER_WIDTH, 1 each, user signal widths

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- axi_req_i  input  axi_conf::req_t  upstream request (aw, w, ar payloads; aw_valid, w_valid, ar_valid, b_ready, r_ready)
- axi_resp_o  output  axi_conf::resp_t  upstream response (b, r payloads; b_valid, r_valid, aw_ready, w_ready, ar_ready)
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  output  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/AWUSER_WIDTH  AW payload
- m_axi_awvalid  output  1  AW valid; m_axi_awready  input  1
- m_axi_w{data,strb,last,user}  output  DATA_WIDTH/STRB_WIDTH/1/WUSER_WIDTH  W payload
- m_axi_wvalid  output  1  W valid; m_axi_wready  input  1
- m_axi_b{id,resp,user}  input  ID_WIDTH/2/BUSER_WIDTH  B payload
- m_axi_bvalid  input  1  B valid; m_axi_bready  output  1
- m_axi_ar{...}  output  same widths as AW, ARUSER_WIDTH  AR payload
- m_axi_arvalid  output  1  AR valid; m_axi_arready  input  1
- m_axi_r{id,data,resp,last,user}  input  ID_WIDTH/DATA_WIDTH/2/1/RUSER_WIDTH  R payload
- m_axi_rvalid  input  1  R valid; m_axi_rready  output  1

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: every valid output and every ready output is 0. All payload registers are 0.
- Ready release: a run flop, reset to 0, goes to 1 on the first rising edge after rst_ni deasserts. Ready outputs are 0 while run is 0.
- Channel mapping:
  - AW, W, AR forward: axi_req_i feeds the buffer, which drives m_axi_*.
  - B, R reverse: m_axi_* feeds the buffer, which drives axi_resp_o.
- Per-channel buffer: 2-entry FIFO with occupancy 0..2.
  - in_ready = run & (occ != 2), driven from registers.
  - out_valid = (occ != 0).
  - out_payload = head entry, always a register output.
- Push on in_valid & in_ready; pop on out_valid & out_ready.
  - occ 0, push: occ 1. Data is visible at the output the next cycle (latency 1).
  - occ 1, push and pop in the same cycle: occ stays 1 and the new entry becomes head. No bubble; sustains 1 beat/cycle.
  - occ 1, push only: occ 2, in_ready drops the next cycle.
  - occ 2: no push is possible. A pop gives occ 1 and in_ready rises the next cycle.
- Ordering is strict FIFO per channel. There is no reordering across channels and no AW/W coupling.
- While out_valid & !out_ready, the head payload is held stable. This satisfies the AXI stability rule.
- aw.atop is not forwarded. Upstream must not issue atomics.
- Reset mid-transfer flushes all buffers (occ := 0). Beats in flight are lost; this is accepted system behaviour.

Decomposition:
- axi_conf package provides req_t/resp_t and the aw/w/b/ar/r channel structs. No new typedefs are needed.
- Sub-module axi_skid_buf #(type T): generic 2-entry buffer with clk_i, rst_ni, run_i, valid_i, ready_o, data_i, valid_o, ready_i, data_o. Instantiate it 5 times, once per channel struct.
- The top level does only flattening and unflattening assigns plus the run flop.

Test Plan:
- Reset: assert rst_ni=0 mid-cycle with aw_valid=1 -> all valids and readys 0 immediately. After release, aw_ready=1 exactly one edge later.
- Latency: AW addr=0x1000_0040, id=0x3, m_axi_awready=1 -> m_axi_awvalid high the next cycle with the same fields. Single-beat handshake completes.
- Throughput: 16-beat W burst with wstrb=0xF and wlast on beat 16, sink always ready -> 16 consecutive wvalid cycles, no bubble, data in order.
- Backpressure: m_axi_arready=0 while 3 AR pushes are attempted -> ar_ready drops after 2 are accepted and the payload holds stable. Set arready=1 -> all 3 exit in order, and the 3rd is accepted one cycle after the first pop.
- Reverse path: R 4-beat burst, rdata=0xA5A5_0000+i, rresp=OKAY, upstream r_ready toggling 1,0,1,0 -> all 4 beats delivered in order, rlast only on beat 4.
- B channel: m_axi_bid=0x7, bresp=SLVERR -> axi_resp_o.b.id=0x7, resp=2'b10, one cycle later.
